// File: rtl/cdm_adapt_csr_bank.sv
// AXI4-Lite control/status register bank for the CDM adapter test designs.
// RW registers sit at word indices 0..NUM_RW-1 and RO registers at
// RO_BASE..RO_BASE+NUM_RO-1. Every other word index is unmapped: it returns
// UNMAPPED_DATA on reads and answers SLVERR to writes.
// One transaction is in flight at a time. If a read and a write arrive
// together while both channels are idle, the read goes first.
module cdm_adapt_csr_bank #(
    parameter int                   C_S_AXI_DATA_WIDTH = 32,
    parameter int                   C_S_AXI_ADDR_WIDTH = 10,
    parameter int                   NUM_RW             = 16,
    parameter int                   NUM_RO             = 16,
    parameter int                   RO_BASE            = 8'h80,
    parameter logic [NUM_RW*32-1:0] RW_RST_VAL         = {NUM_RW{32'h0}},
    parameter logic [NUM_RW-1:0]    SC_MASK            = {NUM_RW{1'b0}},
    parameter logic [31:0]          UNMAPPED_DATA      = 32'h0000DEAD
) (
    input  logic                            axi_aclk,
    input  logic                            axi_areset,
    output logic [NUM_RW*32-1:0]            rw_regs,
    output logic [NUM_RW-1:0]               rw_wr_pulse,
    input  logic [NUM_RO*32-1:0]            ro_regs,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic                            axi_awvalid,
    output logic                            axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                            axi_wvalid,
    output logic                            axi_wready,
    output logic [1:0]                      axi_bresp,
    output logic                            axi_bvalid,
    input  logic                            axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic                            axi_arvalid,
    output logic                            axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                      axi_rresp,
    output logic                            axi_rvalid,
    input  logic                            axi_rready
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int IW = AW - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_RESP}         rd_state_t;

    logic [1:0]        rel_q, rel_d;
    wr_state_t         wr_state_q, wr_state_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic [IW-1:0]     wr_idx_q, wr_idx_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DW-1:0]     rw_q [NUM_RW];
    logic [DW-1:0]     rw_d [NUM_RW];
    logic [NUM_RW-1:0] sc_pend_q, sc_pend_d;
    logic [NUM_RW-1:0] pulse_q, pulse_d;
    logic [DW-1:0]     ro_word [NUM_RO];

    logic          ready_en, wr_busy, rd_busy;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0]   wr_idx_ext, rd_idx_ext;
    logic          wr_hit_rw, rd_hit;
    logic [DW-1:0] rd_word;
    logic          unused_addr_lsbs;

    // The byte-offset bits of both addresses play no part in decode.
    assign unused_addr_lsbs = ^{axi_awaddr[1:0], axi_araddr[1:0]};

    // Split the flat status bus into words, and flatten the RW registers onto the output bus.
    for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_ro
        assign ro_word[gi] = ro_regs[DW*gi +: DW];
    end
    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw
        assign rw_regs[DW*gi +: DW] = rw_q[gi];
    end

    // Handshake qualifiers. No ready is raised until the two-flop reset release has filled.
    assign ready_en    = rel_q[1];
    assign wr_busy     = (wr_state_q != W_IDLE);
    assign rd_busy     = (rd_state_q != R_IDLE);
    assign axi_awready = ready_en && !wr_busy && !rd_busy && !axi_arvalid;
    assign axi_wready  = ready_en && (wr_state_q == W_DATA);
    assign axi_arready = ready_en && !rd_busy && !wr_busy;
    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;
    assign b_hs        = bvalid_q && axi_bready;
    assign ar_hs       = axi_arvalid && axi_arready;
    assign r_hs        = rvalid_q && axi_rready;

    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign rw_wr_pulse = pulse_q;

    // Reset release: shift ones into a two-stage pipe.
    assign rel_d = {rel_q[0], 1'b1};

    // The index is decoded in full, so no word aliases onto another.
    assign wr_idx_ext = 32'(wr_idx_q);
    assign rd_idx_ext = 32'(axi_araddr[AW-1:2]);

    // Read decode: RW value, RO slice, or the unmapped pattern.
    always_comb begin
        rd_word = UNMAPPED_DATA;
        rd_hit  = 1'b0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (rd_idx_ext == i) begin
                rd_word = rw_q[i];
                rd_hit  = 1'b1;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (rd_idx_ext == RO_BASE + j) begin
                rd_word = ro_word[j];
                rd_hit  = 1'b1;
            end
        end
    end

    // RW register update. A write merges the strobed bytes, raises the pulse,
    // and arms the self-clear of the start bit for the following cycle.
    always_comb begin
        wr_hit_rw = 1'b0;
        for (int i = 0; i < NUM_RW; i++) begin
            rw_d[i]      = rw_q[i];
            pulse_d[i]   = 1'b0;
            sc_pend_d[i] = 1'b0;
            if (sc_pend_q[i]) begin
                rw_d[i][0] = 1'b0;
            end
            if (wr_idx_ext == i) begin
                wr_hit_rw = 1'b1;
                if (w_hs) begin
                    for (int k = 0; k < NB; k++) begin
                        if (axi_wstrb[k]) begin
                            rw_d[i][8*k +: 8] = axi_wdata[8*k +: 8];
                        end
                    end
                    pulse_d[i]   = 1'b1;
                    sc_pend_d[i] = SC_MASK[i] & axi_wstrb[0] & axi_wdata[0];
                end
            end
        end
    end

    // Write channel FSM: the address is accepted first, then the data beat, then the response.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    wr_idx_d   = axi_awaddr[AW-1:2];
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_hit_rw ? RESP_OKAY : RESP_SLVERR;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    bvalid_d   = 1'b0;
                    bresp_d    = RESP_OKAY;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read channel FSM: data is captured at the AR handshake and held until R completes.
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_word;
                    rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (r_hs) begin
                    rvalid_d   = 1'b0;
                    rdata_d    = '0;
                    rresp_d    = RESP_OKAY;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // State registers. Reset aborts any transaction in flight at once.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            rel_q      <= '0;
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_idx_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            sc_pend_q  <= '0;
            pulse_q    <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                rw_q[i] <= RW_RST_VAL[DW*i +: DW];
            end
        end else begin
            rel_q      <= rel_d;
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_idx_q   <= wr_idx_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            sc_pend_q  <= sc_pend_d;
            pulse_q    <= pulse_d;
            for (int i = 0; i < NUM_RW; i++) begin
                rw_q[i] <= rw_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cdm_adapt_csr_bank.sv
// Directed bench for cdm_adapt_csr_bank.
// The register map is modelled as plain arrays that are updated once per transaction.
// Hand-computed literals pin the values that matter.
module tb_cdm_adapt_csr_bank;

    localparam int NRW = 16;
    localparam int NRO = 16;
    localparam int TMO = 100;
    localparam logic [NRW*32-1:0] RST_VAL = (512'hCAFEF00D << 96) | (512'h80000001 << 480);
    localparam logic [NRW-1:0]    SC      = 16'h0001;
    localparam logic [31:0]       DEAD    = 32'h0000DEAD;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRW*32-1:0] rw_regs;
    logic [NRW-1:0]    rw_wr_pulse;
    logic [NRO*32-1:0] ro_in;
    logic [9:0]        awaddr, araddr;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;

    int             n_checks = 0;
    int             n_pass   = 0;
    logic           chk_on   = 1'b0;
    logic [31:0]    m_rw [NRW];
    logic [NRW-1:0] m_pulse;

    cdm_adapt_csr_bank #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(10), .NUM_RW(NRW), .NUM_RO(NRO),
        .RO_BASE(8'h80), .RW_RST_VAL(RST_VAL), .SC_MASK(SC), .UNMAPPED_DATA(DEAD)
    ) dut (
        .axi_aclk(clk), .axi_areset(rst), .rw_regs(rw_regs), .rw_wr_pulse(rw_wr_pulse),
        .ro_regs(ro_in),
        .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic tmo(input string name);
        n_checks++;
        $display("FAIL timeout_%s: got no handshake expected one within %0d cycles at %0t", name, TMO, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NRW; i++) m_rw[i] = RST_VAL[32*i +: 32];
        m_pulse = '0;
    endfunction

    // Map semantics: RW below 16, RO in 0x80..0x8F, everything else unmapped.
    function automatic void model_read(input logic [9:0] addr, output logic [31:0] d, output logic [1:0] r);
        int idx = int'(addr[9:2]);
        if (idx < NRW) begin
            d = m_rw[idx]; r = 2'b00;
        end else if (idx >= 'h80 && idx < 'h80 + NRO) begin
            d = ro_in[(idx - 'h80)*32 +: 32]; r = 2'b00;
        end else begin
            d = DEAD; r = 2'b10;
        end
    endfunction

    function automatic logic [1:0] model_write(input logic [9:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb, output logic sc_hit);
        int idx = int'(addr[9:2]);
        sc_hit = 1'b0;
        if (idx >= NRW) return 2'b10;
        for (int k = 0; k < 4; k++) if (strb[k]) m_rw[idx][8*k +: 8] = data[8*k +: 8];
        m_pulse[idx] = 1'b1;
        sc_hit = SC[idx] && strb[0] && data[0];
        return 2'b00;
    endfunction

    // Every cycle: the register image and the write pulses must match the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NRW; i++) chk("rw_regs", rw_regs[32*i +: 32], m_rw[i]);
            chk("rw_wr_pulse", 32'(rw_wr_pulse), 32'(m_pulse));
        end
    end

    task automatic axi_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int bdelay, output logic [1:0] got_resp, output logic [15:0] got_pulse,
                             output time aw_time);
        int cnt;
        logic [1:0] exp_resp;
        logic sc_hit;
        @(posedge clk); #1;
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b0;
        cnt = 0; @(negedge clk);
        while (!awready && cnt < TMO) begin @(negedge clk); cnt++; end
        if (!awready) tmo("awready");
        @(posedge clk); aw_time = $time; #1 awvalid = 1'b0;
        cnt = 0; @(negedge clk);
        while (!wready && cnt < TMO) begin @(negedge clk); cnt++; end
        if (!wready) tmo("wready");
        @(posedge clk);
        exp_resp = model_write(addr, data, strb, sc_hit);
        #1 wvalid = 1'b0;
        @(negedge clk);
        got_resp = bresp; got_pulse = rw_wr_pulse;
        chk("bvalid_rise", 32'(bvalid), 32'd1);
        chk("bresp_model", 32'(bresp), 32'(exp_resp));
        @(posedge clk);
        m_pulse = '0;
        if (sc_hit) m_rw[addr[9:2]][0] = 1'b0;
        #1;
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(bvalid), 32'd1);
            chk("bresp_hold", 32'(bresp), 32'(exp_resp));
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        chk("bvalid_drop", 32'(bvalid), 32'd0);
        $display("WR addr=%03h data=%08h strb=%h bresp=%0d", addr, data, strb, got_resp);
    endtask

    task automatic axi_read(input logic [9:0] addr, input int hold, output logic [31:0] got_data,
                            output logic [1:0] got_resp, output time r_time);
        int cnt;
        logic [31:0] exp_d;
        logic [1:0] exp_r;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        cnt = 0; @(negedge clk);
        while (!arready && cnt < TMO) begin @(negedge clk); cnt++; end
        if (!arready) tmo("arready");
        @(posedge clk);
        model_read(addr, exp_d, exp_r);
        #1 arvalid = 1'b0;
        cnt = 0; @(negedge clk);
        while (!rvalid && cnt < TMO) begin @(negedge clk); cnt++; end
        if (!rvalid) tmo("rvalid");
        got_data = rdata; got_resp = rresp;
        chk("rdata_model", rdata, exp_d);
        chk("rresp_model", 32'(rresp), 32'(exp_r));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rvalid_hold", 32'(rvalid), 32'd1);
            chk("rdata_hold", rdata, exp_d);
        end
        @(posedge clk); #1 rready = 1'b1;
        @(posedge clk); r_time = $time; #1 rready = 1'b0;
        @(negedge clk);
        chk("rvalid_drop", 32'(rvalid), 32'd0);
        chk("rdata_clear", rdata, 32'd0);
        $display("RD addr=%03h data=%08h rresp=%0d", addr, got_data, got_resp);
    endtask

    logic [31:0] d;
    logic [1:0]  r, wr1;
    logic [15:0] p, wp1;
    time         t_rd, t_aw, t_dummy;

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = 10'h00C; arvalid = 1'b1; rready = 1'b0;
        ro_in = '0;
        for (int j = 0; j < NRO; j++) ro_in[32*j +: 32] = 32'h5000_0000 + 32'(j);
        ro_in[31:0] = 32'h1234_5678;
        model_reset();

        // Reset state, with arvalid held high throughout.
        @(posedge clk); chk_on = 1'b1;
        @(negedge clk);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp", 32'({bresp, rresp}), 32'd0);
        chk("rst_reg3", rw_regs[127:96], 32'hCAFE_F00D);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); chk("release_arready_c1", 32'(arready), 32'd0);
        @(negedge clk); chk("release_arready_c2", 32'(arready), 32'd0);
        @(negedge clk); chk("release_arready_c3", 32'(arready), 32'd1);
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk);
        chk("release_rvalid", 32'(rvalid), 32'd1);
        chk("release_rdata", rdata, 32'hCAFE_F00D);
        chk("release_rresp", 32'(rresp), 32'd0);
        @(posedge clk); #1 rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        @(negedge clk); chk("release_rvalid_drop", 32'(rvalid), 32'd0);

        // Full write and read-back of word 1.
        axi_write(10'h004, 32'hA5A5_1234, 4'hF, 0, r, p, t_dummy);
        chk("w1_bresp", 32'(r), 32'd0);
        chk("w1_pulse", 32'(p), 32'h0002);
        axi_read(10'h004, 0, d, r, t_dummy);
        chk("r1_data", d, 32'hA5A5_1234);
        chk("r1_rresp", 32'(r), 32'd0);

        // Byte strobes 0 and 2 only.
        axi_write(10'h004, 32'hFFFF_FFFF, 4'hF, 1, r, p, t_dummy);
        axi_write(10'h004, 32'h0000_0000, 4'b0101, 2, r, p, t_dummy);
        axi_read(10'h004, 0, d, r, t_dummy);
        chk("partial_data", d, 32'hFF00_FF00);

        // Self-clearing start bit in word 0.
        axi_write(10'h000, 32'h0000_0003, 4'hF, 0, r, p, t_dummy);
        chk("sc_reg0", rw_regs[31:0], 32'h0000_0002);
        axi_read(10'h000, 0, d, r, t_dummy);
        chk("sc_read", d, 32'h0000_0002);

        // Writes outside the RW range are rejected.
        axi_write(10'h204, 32'hFFFF_FFFF, 4'hF, 0, r, p, t_dummy);
        chk("ro_wr_bresp", 32'(r), 32'd2);
        chk("ro_wr_pulse", 32'(p), 32'd0);
        axi_write(10'h040, 32'h1357_9BDF, 4'hF, 0, r, p, t_dummy);
        chk("unmap_wr_bresp", 32'(r), 32'd2);
        chk("unmap_wr_pulse", 32'(p), 32'd0);

        // Read decode at the edges of the map.
        axi_read(10'h3FC, 0, d, r, t_dummy);
        chk("unmap_3fc_data", d, 32'h0000_DEAD);
        chk("unmap_3fc_rresp", 32'(r), 32'd2);
        axi_read(10'h200, 0, d, r, t_dummy);
        chk("ro0_data", d, 32'h1234_5678);
        chk("ro0_rresp", 32'(r), 32'd0);
        axi_read(10'h204, 0, d, r, t_dummy);
        chk("ro1_unaffected", d, 32'h5000_0001);
        axi_read(10'h23C, 0, d, r, t_dummy);
        chk("ro_last", d, 32'h5000_000F);
        axi_read(10'h240, 0, d, r, t_dummy);
        chk("above_ro_rresp", 32'(r), 32'd2);
        axi_read(10'h040, 0, d, r, t_dummy);
        chk("above_rw_data", d, 32'h0000_DEAD);
        axi_read(10'h03C, 0, d, r, t_dummy);
        chk("rw_last", d, 32'h8000_0001);
        axi_read(10'h007, 0, d, r, t_dummy);
        chk("addr_lsb_ignored", d, 32'hFF00_FF00);

        // Read and write collide; the read wins and rready is held low for 5 cycles.
        fork
            axi_read(10'h00C, 5, d, r, t_rd);
            axi_write(10'h008, 32'h1111_2222, 4'hF, 3, wr1, wp1, t_aw);
            begin
                @(posedge clk); @(negedge clk);
                chk("collide_awready", 32'(awready), 32'd0);
                chk("collide_arready", 32'(arready), 32'd1);
            end
        join
        chk("collide_rdata", d, 32'hCAFE_F00D);
        chk("collide_read_first", 32'(t_aw > t_rd), 32'd1);
        chk("collide_bresp", 32'(wr1), 32'd0);
        axi_read(10'h008, 0, d, r, t_dummy);
        chk("collide_wr_data", d, 32'h1111_2222);

        // Reset asserted while a read response is pending.
        @(posedge clk); #1 araddr = 10'h004; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk); chk("midrst_rvalid_before", 32'(rvalid), 32'd1);
        #1 rst = 1'b1; model_reset();
        #1;
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_arready", 32'(arready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        axi_read(10'h004, 0, d, r, t_dummy);
        chk("midrst_reg1", d, 32'h0000_0000);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cdm_adapt_csr_bank.md
Name: cdm_adapt_csr_bank

Overview:
- Parametrised AXI4-Lite control/status register bank for the CDM adapter test designs.
- Generalises the fixed MSGST/MSGLD/ST2M/M2ST register file into a bank with configurable RW/RO register counts, byte-strobe writes, SLVERR decode, self-clearing start bits and per-register write-strobe pulses.
- Sits between the host AXI-Lite master and the traffic engines (MSGST/MSGLD/ST2M/M2ST), which consume RW registers and report status/counters through RO registers.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 10, AXI-Lite address width; the word index is addr[ADDR_WIDTH-1:2].
- NUM_RW, 16, number of RW registers, located at word indices 0..NUM_RW-1.
- NUM_RO, 16, number of RO registers, located at word indices RO_BASE..RO_BASE+NUM_RO-1.
- RO_BASE, 8'h80, word index of the first RO register; must be >= NUM_RW.
- RW_RST_VAL, {NUM_RW{32'h0}}, flattened per-register reset values.
- SC_MASK, {NUM_RW{1'b0}}, per-RW-register enable for self-clearing bit 0 (start bits).
- UNMAPPED_DATA, 32'h0000DEAD, read data returned for unmapped addresses.

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_areset  in  1  asynchronous, active-high reset.
- rw_regs  out  NUM_RW*32  flattened RW register values; register i occupies [32i+31:32i].
- rw_wr_pulse  out  NUM_RW  one-cycle pulse when register i is written with OKAY.
- ro_regs  in  NUM_RO*32  flattened status/counter inputs, sampled on read.
- axi_awaddr in ADDR_W; axi_awvalid in 1; axi_awready out 1.
- axi_wdata in 32; axi_wstrb in 4; axi_wvalid in 1; axi_wready out 1.
- axi_bresp out 2; axi_bvalid out 1; axi_bready in 1.
- axi_araddr in ADDR_W; axi_arvalid in 1; axi_arready out 1.
- axi_rdata out 32; axi_rresp out 2; axi_rvalid out 1; axi_rready in 1.

Behaviour:
- Reset (async assert, synchronous release):
  - rw_regs = RW_RST_VAL; rw_wr_pulse = 0.
  - All ready/valid outputs = 0; rdata = 0; bresp = rresp = 0.
  - awready, wready and arready stay 0 for 2 cycles after reset deasserts (two-flop release).
- Write channel, FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready = !rd_busy && !arvalid. On AW handshake, latch the address and move to W_DATA.
  - W_DATA: wready = 1. On W handshake, update the register and move to W_RESP.
  - W_RESP: bvalid is asserted on the cycle after the W handshake and held until bready; return to W_IDLE on the B handshake.
  - Only AW-before-W and same-cycle-W is supported. W beats are not accepted in W_IDLE.
- Write decode:
  - Word index < NUM_RW: for each byte k with wstrb[k]=1, reg[8k+7:8k] <= wdata[8k+7:8k]. bresp = OKAY (2'b00). rw_wr_pulse[i] = 1 for exactly the cycle bvalid first rises.
  - Any other index (RO or unmapped): no update, no pulse, bresp = SLVERR (2'b10).
- Self-clear (SC_MASK[i]=1):
  - Bit 0 of register i is forced to 0 one cycle after it is written as 1, so it reads 1 for exactly one cycle.
  - Writing 0 has no extra effect.
- Read channel, FSM R_IDLE -> R_RESP:
  - R_IDLE: arready = !wr_busy (wr_busy = write FSM not in W_IDLE).
  - On AR handshake, rvalid rises the next cycle with data registered at that edge: RW register value, ro_regs slice, or UNMAPPED_DATA.
  - rresp = OKAY for mapped addresses, SLVERR for unmapped.
  - rdata and rresp are held stable while rvalid && !rready. On the R handshake, rvalid -> 0, rdata -> 0, and the FSM returns to R_IDLE.
- Arbitration: if arvalid and awvalid are both high in the same cycle with both channels idle, the read wins and awready = 0 that cycle. One transaction is outstanding at a time.
- Coherency: a RW read issued after a write's B handshake returns the written value. An RO read reflects ro_regs at the AR-handshake cycle.
- Reset mid-transaction: all FSMs abort to idle, and any pending bvalid/rvalid drops immediately.
- Address bits [1:0] are ignored. Word-index bits above log2 of the map range are decoded in full, with no aliasing.

Test Plan:
- Reset release: hold arvalid=1 through reset -> arready=0 for the 2 cycles after deassert, then 1; rw_regs = RW_RST_VAL.
- Full write then read of word 0x01, data 32'hA5A5_1234, wstrb 4'hF -> bresp=OKAY; rw_wr_pulse[1] high for 1 cycle; read returns A5A5_1234 with rresp=OKAY.
- Partial strobe: reg 0x01 = 32'hFFFF_FFFF, write 32'h0000_0000 with wstrb 4'b0101 -> reads 32'hFF00_FF00.
- Self-clear with SC_MASK[0]=1: write 32'h0000_0003 to word 0 -> bit0=1 for 1 cycle, then rw_regs[31:0] = 32'h0000_0002.
- Error decode: write to RO_BASE+1 -> bresp=2'b10, ro unaffected, no pulse. Read of unmapped 0x3FC -> rdata 32'h0000DEAD, rresp=2'b10. Read of RO_BASE with ro_regs[31:0]=32'h1234_5678 -> 32'h1234_5678, OKAY.
- Collision/backpressure: arvalid and awvalid in the same cycle -> read completes first. With rready held low for 5 cycles, rvalid and rdata stay stable. The write completes after R_IDLE, and bvalid is held until bready.
